hazard_ctrl_unit: RTL

//  Parametrised pipeline hazard controller for the 5-stage RV32 core. It handles:
//   - load-use stalls of configurable length;
//   - multi-cycle MUL/DIV occupancy of the Execute stage;
//   - data-memory wait states;
//   - taken-branch flushes.
//  It drives the per-stage stall and flush enables of the F/D/E/M/W pipeline registers,
//  and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core: load-use stalls, multi-cycle MUL/DIV,
// data-memory wait states and taken-branch flushes, plus a saturating stall-cycle counter.
module hazard_ctrl_unit #(
   parameter int REG_AW         = 5,
   parameter int LOAD_USE_STALL = 1,
   parameter int MDU_LAT        = 4,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic              rs1_used_d,
   input  logic              rs2_used_d,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              mem_read_e,
   input  logic              mdu_op_e,
   input  logic              branch_taken_e,
   input  logic              mem_req_m,
   input  logic              dmem_ready,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic              flush_w,
   output logic              mdu_busy,
   output logic [CNT_W-1:0]  stall_count
);

   localparam int MAX_LAT = (LOAD_USE_STALL > MDU_LAT) ? LOAD_USE_STALL : MDU_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LU_STALL = 2'd1,
      MDU_BUSY = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic luh, mem_wait;
   logic sf, sd, se, sm, fd, fe, fm, fw;

   assign luh = mem_read_e && (rd_e != '0) &&
                ((rs1_used_d && (rs1_d == rd_e)) || (rs2_used_d && (rs2_d == rd_e)));
   assign mem_wait = mem_req_m && !dmem_ready;

   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
      fd = 1'b0; fe = 1'b0; fm = 1'b0; fw = 1'b0;

      if (mem_wait) begin
         sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
         fw = 1'b1;
      end else begin
         unique case (state_q)
            MDU_BUSY: begin
               sf = 1'b1; sd = 1'b1; se = 1'b1;
               fm = 1'b1;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == '0) state_d = IDLE;
            end
            LU_STALL: begin
               sf = 1'b1; sd = 1'b1;
               fe = 1'b1;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == '0) state_d = IDLE;
            end
            default: begin
               if (mdu_op_e && (MDU_LAT > 1)) begin
                  sf = 1'b1; sd = 1'b1; se = 1'b1;
                  fm = 1'b1;
                  if (MDU_LAT > 2) begin
                     cnt_d   = CW'(MDU_LAT - 3);
                     state_d = MDU_BUSY;
                  end
               end else if (branch_taken_e) begin
                  // The Decode instruction is wrong-path, so a coincident load-use is moot.
                  fd = 1'b1;
                  fe = 1'b1;
               end else if (luh) begin
                  sf = 1'b1; sd = 1'b1;
                  fe = 1'b1;
                  if (LOAD_USE_STALL > 1) begin
                     cnt_d   = CW'(LOAD_USE_STALL - 2);
                     state_d = LU_STALL;
                  end
               end
            end
         endcase
      end
   end

   // Outputs are forced low during reset even though several paths are purely combinational.
   assign stall_f  = sf && rst_n;
   assign stall_d  = sd && rst_n;
   assign stall_e  = se && rst_n;
   assign stall_m  = sm && rst_n;
   assign flush_d  = fd && rst_n;
   assign flush_e  = fe && rst_n;
   assign flush_m  = fm && rst_n;
   assign flush_w  = fw && rst_n;
   assign mdu_busy = (state_q == MDU_BUSY);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   assign stall_count = stall_cnt_q;

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
